// File: rtl/lms_pkg.sv
// Shared types and timing helpers for the LMS adaptive FIR control sequencer.
package lms_pkg;

  localparam int unsigned LMS_DEFAULT_TAPS = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FILTER = 3'd2,
    ST_ERROR  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } lms_state_t;

  // Both passes run one extra cycle past the last tap to absorb RAM read latency.
  function automatic int unsigned filter_len(input int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned update_len(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/lms_tap_addr_gen.sv
// Circular sample-RAM read address: (wr_ptr - k) mod NUM_TAPS, valid for k < NUM_TAPS.
module lms_tap_addr_gen
  import lms_pkg::*;
#(
  parameter int unsigned NUM_TAPS = LMS_DEFAULT_TAPS
) (
  input  logic [$clog2(NUM_TAPS)-1:0] wr_ptr_i,
  input  logic [$clog2(NUM_TAPS)-1:0] k_i,
  output logic [$clog2(NUM_TAPS)-1:0] tap_addr_o
);

  localparam int unsigned ADDR_W = $clog2(NUM_TAPS);
  localparam int unsigned SUM_W  = ADDR_W + 1;

  logic [SUM_W-1:0] sum_c;

  // Bias by N so the subtraction never underflows; one conditional subtract folds it back.
  always_comb begin
    sum_c = {1'b0, wr_ptr_i} + SUM_W'(NUM_TAPS) - {1'b0, k_i};
    if (sum_c >= SUM_W'(NUM_TAPS)) begin
      tap_addr_o = ADDR_W'(sum_c - SUM_W'(NUM_TAPS));
    end else begin
      tap_addr_o = ADDR_W'(sum_c);
    end
  end

endmodule

// File: rtl/lms_sequencer.sv
// Sequencer for a time-multiplexed LMS FIR: load, filter pass, error latch, coefficient update.
// Optional macro LMS_ADAPT_GATE_EN adds adapt_en_in to skip the update pass.
module lms_sequencer
  import lms_pkg::*;
#(
  parameter int unsigned NUM_TAPS = LMS_DEFAULT_TAPS
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        ready_in,
`ifdef LMS_ADAPT_GATE_EN
  input  logic                        adapt_en_in,
`endif
  output logic                        sample_we_out,
  output logic [$clog2(NUM_TAPS)-1:0] sample_addr_out,
  output logic [$clog2(NUM_TAPS)-1:0] coeff_raddr_out,
  output logic                        coeff_we_out,
  output logic [$clog2(NUM_TAPS)-1:0] coeff_waddr_out,
  output logic                        mac_clr_out,
  output logic                        mac_en_out,
  output logic                        err_latch_out,
  output logic                        done_out,
  output logic                        busy_out,
  output logic                        overrun_out
);

  localparam int unsigned ADDR_W     = $clog2(NUM_TAPS);
  localparam int unsigned K_W        = $clog2(NUM_TAPS + 1);
  localparam int unsigned FILTER_LEN = filter_len(NUM_TAPS);
  localparam int unsigned UPDATE_LEN = update_len(NUM_TAPS);

  lms_state_t        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              overrun_q, overrun_d;

  logic [ADDR_W-1:0] tap_addr;
  logic [ADDR_W-1:0] k_addr;
  logic              tap_valid;

  assign k_addr    = ADDR_W'(k_q);
  assign tap_valid = (k_q < K_W'(NUM_TAPS));

  lms_tap_addr_gen #(
    .NUM_TAPS (NUM_TAPS)
  ) u_tap_addr_gen (
    .wr_ptr_i   (wr_ptr_q),
    .k_i        (k_addr),
    .tap_addr_o (tap_addr)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      wr_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wr_ptr_q  <= wr_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state, tap counter and write pointer.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wr_ptr_d  = wr_ptr_q;
    overrun_d = ready_in && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (ready_in) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        k_d     = '0;
        state_d = ST_FILTER;
      end
      ST_FILTER: begin
        if (k_q == K_W'(FILTER_LEN - 1)) begin
          k_d     = '0;
          state_d = ST_ERROR;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_ERROR: begin
        k_d     = '0;
        state_d = ST_UPDATE;
`ifdef LMS_ADAPT_GATE_EN
        if (!adapt_en_in) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_UPDATE: begin
        if (k_q == K_W'(UPDATE_LEN - 1)) begin
          k_d     = '0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_DONE: begin
        k_d     = '0;
        state_d = ST_IDLE;
        // Explicit wrap so non-power-of-two tap counts stay in range.
        if (wr_ptr_q == ADDR_W'(NUM_TAPS - 1)) begin
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        k_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state only; ready_in never reaches an output.
  always_comb begin
    sample_we_out   = 1'b0;
    sample_addr_out = '0;
    coeff_raddr_out = '0;
    coeff_we_out    = 1'b0;
    coeff_waddr_out = '0;
    mac_clr_out     = 1'b0;
    mac_en_out      = 1'b0;
    err_latch_out   = 1'b0;
    done_out        = 1'b0;
    busy_out        = (state_q != ST_IDLE);
    overrun_out     = overrun_q;
    case (state_q)
      ST_LOAD: begin
        sample_we_out   = 1'b1;
        sample_addr_out = wr_ptr_q;
        mac_clr_out     = 1'b1;
      end
      ST_FILTER: begin
        if (tap_valid) begin
          sample_addr_out = tap_addr;
          coeff_raddr_out = k_addr;
        end
        mac_en_out = (k_q != '0);
      end
      ST_ERROR: begin
        err_latch_out = 1'b1;
      end
      ST_UPDATE: begin
        if (tap_valid) begin
          sample_addr_out = tap_addr;
          coeff_raddr_out = k_addr;
        end
        // Write-back trails the read by one cycle.
        if (k_q != '0) begin
          coeff_we_out    = 1'b1;
          coeff_waddr_out = ADDR_W'(k_q - K_W'(1));
        end
      end
      ST_DONE: begin
        done_out = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lms_sequencer.sv
// Directed self-checking bench for lms_sequencer (N=32 and N=5 instances).
`timescale 1ns/1ps
module tb_lms_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic ready32, ready5;
`ifdef LMS_ADAPT_GATE_EN
  logic adapt32, adapt5;
`endif

  logic       swe32, cwe32, clr32, men32, err32, done32, busy32, ovr32;
  logic [4:0] saddr32, craddr32, cwaddr32;
  logic       swe5, cwe5, clr5, men5, err5, done5, busy5, ovr5;
  logic [2:0] saddr5, craddr5, cwaddr5;

  logic [31:0] obs32, obs5;
  int checks = 0;
  int errors = 0;
  int wp32   = 0;
  int wp5    = 0;

  always #5 clk = ~clk;

  lms_sequencer #(.NUM_TAPS(32)) dut32 (
    .clk_in(clk), .rst_in(rst), .ready_in(ready32),
`ifdef LMS_ADAPT_GATE_EN
    .adapt_en_in(adapt32),
`endif
    .sample_we_out(swe32), .sample_addr_out(saddr32), .coeff_raddr_out(craddr32),
    .coeff_we_out(cwe32), .coeff_waddr_out(cwaddr32), .mac_clr_out(clr32),
    .mac_en_out(men32), .err_latch_out(err32), .done_out(done32),
    .busy_out(busy32), .overrun_out(ovr32)
  );

  lms_sequencer #(.NUM_TAPS(5)) dut5 (
    .clk_in(clk), .rst_in(rst), .ready_in(ready5),
`ifdef LMS_ADAPT_GATE_EN
    .adapt_en_in(adapt5),
`endif
    .sample_we_out(swe5), .sample_addr_out(saddr5), .coeff_raddr_out(craddr5),
    .coeff_we_out(cwe5), .coeff_waddr_out(cwaddr5), .mac_clr_out(clr5),
    .mac_en_out(men5), .err_latch_out(err5), .done_out(done5),
    .busy_out(busy5), .overrun_out(ovr5)
  );

  assign obs32 = {8'(cwaddr32), 8'(craddr32), 8'(saddr32),
                  ovr32, swe32, cwe32, clr32, men32, err32, done32, busy32};
  assign obs5  = {8'(cwaddr5), 8'(craddr5), 8'(saddr5),
                  ovr5, swe5, cwe5, clr5, men5, err5, done5, busy5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected output vector at cycle c after the accepting edge, from the published timeline.
  function automatic logic [31:0] exp_vec(input int n, input int wp, input int c,
                                          input bit adapt, input bit ovr);
    logic [31:0] v;
    int k;
    v    = '0;
    v[7] = ovr;
    if (c == 1) begin
      v[0] = 1'b1; v[4] = 1'b1; v[6] = 1'b1; v[15:8] = 8'(wp);
    end else if (c >= 2 && c <= n + 2) begin
      k = c - 2;
      v[0] = 1'b1;
      if (k < n) begin
        v[15:8]  = 8'((wp - k + n) % n);
        v[23:16] = 8'(k);
      end
      if (k >= 1) v[3] = 1'b1;
    end else if (c == n + 3) begin
      v[0] = 1'b1; v[2] = 1'b1;
    end else if (adapt && c >= n + 4 && c <= 2 * n + 4) begin
      k = c - n - 4;
      v[0] = 1'b1;
      if (k < n) begin
        v[15:8]  = 8'((wp - k + n) % n);
        v[23:16] = 8'(k);
      end
      if (k >= 1) begin
        v[5] = 1'b1; v[31:24] = 8'(k - 1);
      end
    end else if (c == (adapt ? 2 * n + 5 : n + 4)) begin
      v[0] = 1'b1; v[1] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] obs(input int sel);
    return sel ? obs5 : obs32;
  endfunction

  // One strobed pass; o1/o2 are cycles with an extra strobe, abort_c a cycle to reset in.
  task automatic run_pass(input int sel, input bit adapt, input int o1, input int o2,
                          input int abort_c);
    int n, wp, last;
    bit ovr;
    n    = sel ? 5 : 32;
    wp   = sel ? wp5 : wp32;
    last = (adapt ? 2 * n + 5 : n + 4) + 2;
    @(negedge clk);
    if (sel) ready5 = 1'b1; else ready32 = 1'b1;
    @(posedge clk); #1;
    ready5 = 1'b0; ready32 = 1'b0;
    for (int c = 1; c <= last; c++) begin
      ovr = (o1 > 0 && c == o1 + 1) || (o2 > 0 && c == o2 + 1);
      check($sformatf("n%0d_wp%0d_c%0d", n, wp, c), obs(sel), exp_vec(n, wp, c, adapt, ovr));
      if (c == abort_c) begin
        #2 rst = 1'b1;
        #1 check("async_rst_zero", obs(sel), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", obs(sel), 32'h0);
        wp32 = 0;
        wp5  = 0;
        return;
      end
      if (c == o1 || c == o2) begin
        if (sel) ready5 = 1'b1; else ready32 = 1'b1;
      end
      @(posedge clk); #1;
      ready5 = 1'b0; ready32 = 1'b0;
    end
    if (sel) wp5 = (wp5 + 1) % n; else wp32 = (wp32 + 1) % n;
  endtask

  initial begin
    rst = 1'b1; ready32 = 1'b0; ready5 = 1'b0;
`ifdef LMS_ADAPT_GATE_EN
    adapt32 = 1'b1; adapt5 = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_n32", obs32, 32'h0);
    check("reset_n5", obs5, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle_n32", obs32, 32'h0);

    // First pass from wr_ptr 0, then 32 more samples at the 512-cycle sample rate.
    run_pass(0, 1'b1, 0, 0, 0);
    for (int i = 1; i < 33; i++) begin
      repeat (440) @(posedge clk);
      run_pass(0, 1'b1, 0, 0, 0);
    end

    // Strobes while busy at cycle 10 and on the DONE cycle.
    repeat (20) @(posedge clk);
    run_pass(0, 1'b1, 10, 69, 0);

    // Async reset mid-update, then a clean pass from wr_ptr 0.
    repeat (20) @(posedge clk);
    run_pass(0, 1'b1, 0, 0, 50);
    check("wp_after_rst", obs32, 32'h0);
    run_pass(0, 1'b1, 0, 0, 0);

    // Non-power-of-two depth: six passes wrap wr_ptr 4 -> 0.
    for (int i = 0; i < 6; i++) begin
      repeat (30) @(posedge clk);
      run_pass(1, 1'b1, 0, 0, 0);
    end

`ifdef LMS_ADAPT_GATE_EN
    repeat (20) @(posedge clk);
    adapt32 = 1'b0;
    run_pass(0, 1'b0, 0, 0, 0);
    adapt32 = 1'b1;
    repeat (20) @(posedge clk);
    run_pass(0, 1'b1, 0, 0, 0);
    adapt5 = 1'b0;
    run_pass(1, 1'b0, 0, 0, 0);
    adapt5 = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lms_sequencer.md
Name: lms_sequencer

Overview:
- Control sequencer for the time-multiplexed LMS adaptive FIR datapath: one MAC, one circular sample RAM, one coefficient RAM.
- On each accepted audio sample strobe it runs three phases in order:
  - a filter pass over all taps;
  - an error-latch cycle;
  - a coefficient update pass.
- Sits between the sample-rate strobe (one sample per 512 clocks) and the datapath RAMs/MAC. It drives addresses, enables and phase strobes only, never data.

Parameters:
- NUM_TAPS, 32: filter length. Must be >= 2. The derived localparam ADDR_W = $clog2(NUM_TAPS) sets the address width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- ready_in  in  1  new-sample strobe, one-cycle pulse
- sample_we_out  out  1  write the new sample into the sample RAM at sample_addr_out
- sample_addr_out  out  ADDR_W  sample RAM address (write or read)
- coeff_raddr_out  out  ADDR_W  coefficient RAM read address
- coeff_we_out  out  1  coefficient RAM write enable
- coeff_waddr_out  out  ADDR_W  coefficient RAM write address
- mac_clr_out  out  1  clear the accumulator
- mac_en_out  out  1  accumulate the product of the current RAM read data
- err_latch_out  out  1  latch error = desired - accumulator
- done_out  out  1  one-cycle pulse; output sample valid
- busy_out  out  1  high in every state except IDLE
- overrun_out  out  1  one-cycle pulse; a strobe arrived while busy and was dropped

Behaviour:
- Output generation:
  - All outputs are decoded only from registered state, tap counter k and wr_ptr.
  - There is no combinational path from ready_in to any output.
- Reset:
  - State returns to IDLE immediately, including mid-pass.
  - k=0, wr_ptr=0, every output 0.
  - Any pass in progress is abandoned. RAM contents are not the block's concern.
- States: IDLE, LOAD, FILTER, ERROR, UPDATE, DONE.
- Timeline, with the accepting edge as cycle 0 and N = NUM_TAPS:
  - IDLE: ready_in=1 at an edge moves to LOAD. k resets to 0.
  - LOAD (cycle 1):
    - sample_we_out=1, sample_addr_out=wr_ptr, mac_clr_out=1.
    - Next state FILTER.
  - FILTER (cycles 2..N+2), k=0..N:
    - For k<N: sample_addr_out=(wr_ptr-k) mod N, wrapping below 0 to N-1; coeff_raddr_out=k.
    - mac_en_out=1 for k>=1, which covers the 1-cycle RAM read latency.
    - At k=N, next state ERROR.
  - ERROR (cycle N+3): err_latch_out=1. Next state UPDATE, k reset to 0.
  - UPDATE (cycles N+4..2N+4), k=0..N:
    - Read addressing is identical to FILTER.
    - For k>=1: coeff_we_out=1, coeff_waddr_out=k-1. This is read-modify-write with one cycle of latency.
    - At k=N, next state DONE.
  - DONE (cycle 2N+5):
    - done_out=1.
    - wr_ptr <= (wr_ptr+1) mod N. Wraps N-1 to 0 and must not assume N is a power of two.
    - Next state IDLE.
- Latency from ready_in to done_out: 2N+5 cycles (69 for N=32), well inside the 512-cycle sample period.
- Overrun:
  - ready_in=1 in any state other than IDLE (DONE included) is dropped.
  - overrun_out pulses on the following cycle; the sequence is unaffected.
  - ready_in=1 in IDLE on the same cycle as DONE→IDLE cannot occur, because DONE takes a full cycle.
- Back-to-back: ready_in on the first IDLE cycle after DONE is accepted normally.
- Default output values:
  - addresses 0 whenever not driven by an active phase;
  - all enables 0 outside their listed cycles.

Optional Feature:
- Macro: LMS_ADAPT_GATE_EN.
- When defined:
  - Adds input port adapt_en_in (1 bit), sampled in ERROR.
  - If adapt_en_in=0, ERROR goes straight to DONE. The UPDATE pass is skipped, no coeff_we_out pulses occur, and latency is N+4.
  - err_latch_out still pulses.
- When undefined:
  - The port is absent and UPDATE always runs.

Decomposition:
- Package lms_pkg holds:
  - typedef enum logic [2:0] lms_state_t;
  - localparam LMS_DEFAULT_TAPS=32;
  - timing localparams FILTER_LEN=NUM_TAPS+1 and UPDATE_LEN=NUM_TAPS+1, written as functions of N.
- One sub-module, lms_tap_addr_gen:
  - Inputs wr_ptr and k; output (wr_ptr-k) mod N.
  - Instantiated once and shared by FILTER and UPDATE.

Test Plan:
- Reset, then ready_in pulse with N=32, wr_ptr=0:
  - LOAD at cycle 1;
  - sample_addr_out sequence 0,31,30,…,1;
  - 32 mac_en_out cycles;
  - err_latch_out at cycle 35;
  - coeff_waddr_out 0..31 with coeff_we_out cycles 37..68;
  - done_out at cycle 69.
- Run 33 back-to-back samples, each strobed 512 cycles apart:
  - wr_ptr wraps 31→0;
  - LOAD address on the 33rd sample is 0;
  - FILTER read order at wr_ptr=5 is 5,4,…,0,31,…,6.
- ready_in asserted at cycle 10 and at the DONE cycle of an active pass: overrun_out pulses the next cycle each time, with no restart and no extra done_out.
- rst_in asserted asynchronously mid-UPDATE (cycle 50):
  - all outputs 0 before the next edge;
  - IDLE follows;
  - the next ready_in gives a clean 69-cycle pass from wr_ptr=0.
- NUM_TAPS=5 build (not a power of two): wrap 4→0 correct and latency 15.
- With LMS_ADAPT_GATE_EN and adapt_en_in=0: no coeff_we_out pulses and done_out at cycle N+4=36. With adapt_en_in=1: matches the first test exactly.
